// File: rtl/sha1pad_if.sv
// Byte-in / word-out stream interface of the SHA-1 message padder.
// The master modport is the padder itself; the slave modport is its environment.
interface sha1pad_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_end;
  logic        out_final;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_first, out_end, out_final
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_end, out_final
  );
endinterface

// File: rtl/sha1pad.sv
// SHA-1 message padder: packs bytes into big-endian words, then emits the 0x80 marker,
// zero fill and the 64-bit bit length, in 16-word blocks.
module sha1pad #(
  parameter int unsigned LEN_W = 61
) (
  input  logic      clk,
  input  logic      reset,
  sha1pad_if.master bus
);

  typedef enum logic [2:0] {StData, StPad, StZero, StLenHi, StLenLo} state_e;

  state_e             state_q, state_d;
  logic [1:0]         pos_q, pos_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        wbuf_q, wbuf_d;
  logic [31:0]        word_q, word_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic               in_fire, out_fire;
  logic [31:0]        byte_word, pad_word;
  logic [63:0]        len_bits;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = valid_q && bus.out_ready;
  assign len_bits = 64'({cnt_q, 3'b000});

  // Buffer with the incoming byte merged in, and the same followed by the 0x80 marker.
  always_comb begin
    case (pos_q)
      2'd0: begin
        byte_word = {bus.in_data, wbuf_q[23:0]};
        pad_word  = {bus.in_data, 24'h80_0000};
      end
      2'd1: begin
        byte_word = {wbuf_q[31:24], bus.in_data, wbuf_q[15:0]};
        pad_word  = {wbuf_q[31:24], bus.in_data, 16'h8000};
      end
      2'd2: begin
        byte_word = {wbuf_q[31:16], bus.in_data, wbuf_q[7:0]};
        pad_word  = {wbuf_q[31:16], bus.in_data, 8'h80};
      end
      default: begin
        byte_word = {wbuf_q[31:8], bus.in_data};
        pad_word  = 32'h8000_0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StData;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StData: begin
        if (out_fire && last_q)                                 state_d = StPad;
        else if (in_fire && bus.in_last && pos_q != 2'd3)       state_d = StPad;
      end
      StPad:   if (out_fire) state_d = (idx_q == 4'd13) ? StLenHi : StZero;
      StZero:  if (out_fire && idx_q == 4'd13) state_d = StLenHi;
      StLenHi: if (out_fire) state_d = StLenLo;
      StLenLo: if (out_fire) state_d = StData;
      default: state_d = StData;
    endcase
  end

  always_comb begin
    pos_d   = pos_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (out_fire) idx_d = idx_q + 4'd1;
    unique case (state_q)
      StData: begin
        if (in_fire) begin
          cnt_d = cnt_q + LEN_W'(1);
          pos_d = pos_q + 2'd1;
          if (pos_q == 2'd3) begin
            word_d  = byte_word;
            valid_d = 1'b1;
            wbuf_d  = '0;
            last_d  = bus.in_last;
          end else if (bus.in_last) begin
            word_d  = pad_word;
            valid_d = 1'b1;
            wbuf_d  = '0;
            pos_d   = 2'd0;
          end else begin
            wbuf_d = byte_word;
          end
        end
        // A final byte at position 3 leaves a full data word; the marker gets a word of its own.
        if (out_fire) begin
          if (last_q) begin
            word_d = 32'h8000_0000;
            last_d = 1'b0;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      StPad, StZero: begin
        if (out_fire) word_d = (idx_q == 4'd13) ? len_bits[63:32] : 32'h0;
      end
      StLenHi: begin
        if (out_fire) word_d = len_bits[31:0];
      end
      StLenLo: begin
        if (out_fire) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          pos_d   = 2'd0;
          idx_d   = 4'd0;
          wbuf_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q   <= 2'd0;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      wbuf_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    bus.in_ready  = !reset && (state_q == StData) && !valid_q;
    bus.out_valid = valid_q;
    bus.out_data  = word_q;
    bus.out_first = valid_q && (idx_q == 4'd0);
    bus.out_end   = valid_q && (idx_q == 4'd15);
    bus.out_final = valid_q && (idx_q == 4'd15) && (state_q == StLenLo);
  end

endmodule

// File: tb/tb_sha1pad.sv
// Scoreboard bench for sha1pad: a byte-level padding model queues expected words,
// a negedge monitor checks every transferred word plus hold/backpressure behaviour.
module tb_sha1pad;

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        endw;
    logic        fin;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset;
  sha1pad_if bus();

  sha1pad #(.LEN_W(61)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;
  int   word_no = 0;
  bit   stalled_this = 0;
  int   stall_left = 0;
  bit   held_v = 0;
  exp_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SHA-1 padding at the byte level: marker, zeros to 56 mod 64, 8-byte big-endian bit length.
  function automatic void model_push(input bq_t msg);
    bq_t         p;
    logic [63:0] bits;
    int          nw;
    exp_t        e;
    p    = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++) begin
      e.data  = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      e.first = (w % 16 == 0);
      e.endw  = (w % 16 == 15);
      e.fin   = (w == nw - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t cur, e;
    if (reset) begin
      held_v = 0;
    end else if (bus.out_valid) begin
      cur = {bus.out_data, bus.out_first, bus.out_end, bus.out_final};
      chk("in_ready_while_word_held", 64'(bus.in_ready), 64'(0));
      if (held_v) chk("hold_stable", 64'(cur), 64'(held));
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h, expected no word", cur.data);
        end else begin
          e = exp_q.pop_front();
          chk("word{data,first,end,final}", 64'(cur), 64'(e));
        end
        word_no++;
        stalled_this = 0;
        held_v = 0;
      end else begin
        held   = cur;
        held_v = 1;
      end
    end else begin
      held_v = 0;
      chk("flags_idle", 64'({bus.out_first, bus.out_end, bus.out_final}), 64'(0));
    end
  end

  // out_ready: 0 = always ready, 1 = random, 2 = 3-cycle stall on words 0, 1 and 15.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_left == 0 && !stalled_this && bus.out_valid &&
              (word_no % 16 == 0 || word_no % 16 == 1 || word_no % 16 == 15)) begin
            stall_left   = 3;
            stalled_this = 1;
          end
          if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic wait_accept();
    int t = 0;
    bit acc = 0;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no in_ready, expected acceptance within 500 cycles");
    end
  endtask

  task automatic send_msg(input bq_t msg, input bit gaps, input bit with_last);
    if (with_last) model_push(msg);
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = with_last && (i == msg.size() - 1);
      wait_accept();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_words_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bq_t m;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'(0));
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_out_data", 64'(bus.out_data), 64'(0));
    chk("reset_flags", 64'({bus.out_first, bus.out_end, bus.out_final}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // "abc", always ready
    m = '{8'h61, 8'h62, 8'h63};
    rdy_mode = 0;
    send_msg(m, 0, 1);
    wait_drain();

    // 55, 56 and 64 bytes: boundaries of the one/two-block split
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h41);
    send_msg(m, 0, 1);
    wait_drain();
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    send_msg(m, 0, 1);
    wait_drain();
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    send_msg(m, 0, 1);
    wait_drain();

    // "abc" with stalls on words 0, 1, 15
    m = '{8'h61, 8'h62, 8'h63};
    word_no  = 0;
    rdy_mode = 2;
    send_msg(m, 0, 1);
    wait_drain();

    // "abc" with random input gaps
    rdy_mode = 0;
    send_msg(m, 1, 1);
    wait_drain();

    // Abort after two bytes, then a clean "abc"
    m = '{8'h11, 8'h22};
    send_msg(m, 0, 0);
    reset = 1'b1;
    #1;
    chk("in_ready_in_reset", 64'(bus.in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 1);
    wait_drain();

    // Random messages with random backpressure and gaps
    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      m = {};
      for (int i = 0; i < int'($urandom_range(1, 140)); i++) m.push_back(8'($urandom));
      send_msg(m, 1'($urandom_range(0, 1)), 1);
      wait_drain();
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
